// File: rtl/mem_resp_pkg.sv
// Shared encodings and defaults for the main-memory responder.
package mem_resp_pkg;

  localparam int unsigned LATENCY_DEFAULT = 4;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned COUNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // A request with both enables high is executed as a write.
  function automatic op_t decode_op(input logic write_enable);
    return write_enable ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Storage array: synchronous write, registered read, synchronous full clear.
module mem_resp_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear wins over any access; read data register holds between reads.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency memory responder: request handshake, latency FSM, op counters.
module main_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_read_enable,
  input  logic               mem_write_enable,
  input  logic [DATA_W-1:0]  mem_write_data,
  output logic [DATA_W-1:0]  mem_read_data,
  output logic               mem_valid,
  output logic               mem_ready,
  output logic               proto_err,
  output logic [COUNT_W-1:0] read_count,
  output logic [COUNT_W-1:0] write_count
);

  // LATENCY=1 skips WAIT and commits on the accepting edge itself.
  localparam bit               DIRECT   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              accept_c;
  logic              enter_resp_c;
  logic              direct_c;
  op_t               cmt_op_c;
  logic [ADDR_W-1:0] cmt_addr_c;
  logic [DATA_W-1:0] cmt_data_c;
  logic              arr_wr_c;
  logic              arr_rd_c;

  // Handshake and commit selection: direct path uses live inputs, else captured request.
  always_comb begin
    accept_c     = mem_ready && (mem_read_enable || mem_write_enable);
    direct_c     = DIRECT && accept_c;
    enter_resp_c = direct_c || ((state_q == WAIT) && (cnt_q == '0));
    cmt_op_c     = direct_c ? decode_op(mem_write_enable) : op_q;
    cmt_addr_c   = direct_c ? mem_addr : addr_q;
    cmt_data_c   = direct_c ? mem_write_data : data_q;
    arr_wr_c     = !rst && enter_resp_c && (cmt_op_c == OP_WRITE);
    arr_rd_c     = !rst && enter_resp_c && (cmt_op_c == OP_READ);
  end

  mem_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .clear   (rst),
    .wr_en   (arr_wr_c),
    .rd_en   (arr_rd_c),
    .addr    (cmt_addr_c),
    .wr_data (cmt_data_c),
    .rd_data (mem_read_data)
  );

  // Latency FSM with registered handshake, strobe, error flag and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      mem_valid   <= 1'b0;
      mem_ready   <= 1'b1;
      proto_err   <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      mem_valid <= enter_resp_c;

      if (accept_c) begin
        op_q   <= decode_op(mem_write_enable);
        addr_q <= mem_addr;
        data_q <= mem_write_data;
        if (mem_read_enable && mem_write_enable) begin
          proto_err <= 1'b1;
        end
      end

      if (enter_resp_c) begin
        if (cmt_op_c == OP_WRITE) begin
          write_count <= write_count + 16'd1;
        end else begin
          read_count <= read_count + 16'd1;
        end
      end

      case (state_q)
        IDLE, RESPOND: begin
          if (accept_c) begin
            if (DIRECT) begin
              state_q   <= RESPOND;
              mem_ready <= 1'b1;
            end else begin
              state_q   <= WAIT;
              cnt_q     <= CNT_LOAD;
              mem_ready <= 1'b0;
            end
          end else begin
            state_q   <= IDLE;
            mem_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q   <= RESPOND;
            mem_ready <= 1'b1;
          end else begin
            cnt_q     <= CNT_W'(cnt_q - 1'b1);
            mem_ready <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench: LATENCY=4 transaction table plus LATENCY=1 streaming and counter wrap.
module tb_main_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // LATENCY=4 instance
  logic        rst4 = 1'b1;
  logic [7:0]  addr4 = '0;
  logic        re4 = 1'b0;
  logic        we4 = 1'b0;
  logic [7:0]  wd4 = '0;
  logic [7:0]  rd4;
  logic        v4, rdy4, pe4;
  logic [15:0] rc4, wc4;

  // LATENCY=1 instance
  logic        rst1 = 1'b1;
  logic [7:0]  addr1 = '0;
  logic        re1 = 1'b0;
  logic        we1 = 1'b0;
  logic [7:0]  wd1 = '0;
  logic [7:0]  rd1;
  logic        v1, rdy1, pe1;
  logic [15:0] rc1, wc1;

  main_mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst4), .mem_addr(addr4), .mem_read_enable(re4),
    .mem_write_enable(we4), .mem_write_data(wd4), .mem_read_data(rd4),
    .mem_valid(v4), .mem_ready(rdy4), .proto_err(pe4),
    .read_count(rc4), .write_count(wc4)
  );

  main_mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .mem_addr(addr1), .mem_read_enable(re1),
    .mem_write_enable(we1), .mem_write_data(wd1), .mem_read_data(rd1),
    .mem_valid(v1), .mem_ready(rdy1), .proto_err(pe1),
    .read_count(rc1), .write_count(wc1)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic        exp_pe;
    logic [15:0] exp_rc;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, "_ready"}, 32'(rdy4), 32'd1);
    chk({tag, "_valid"}, 32'(v4), 32'd0);
    chk({tag, "_rdata"}, 32'(rd4), 32'd0);
    chk({tag, "_proto"}, 32'(pe4), 32'd0);
    chk({tag, "_rc"}, 32'(rc4), 32'd0);
    chk({tag, "_wc"}, 32'(wc4), 32'd0);
  endtask

  // Issue one request at a negedge with ready high, then check the 4-cycle response window.
  task automatic run_txn4(input vec_t v, input string tag);
    chk({tag, "_ready_pre"}, 32'(rdy4), 32'd1);
    re4 = v.rd; we4 = v.wr; addr4 = v.addr; wd4 = v.wdata;
    @(posedge clk);
    @(negedge clk);
    re4 = 1'b0; we4 = 1'b0; addr4 = 8'hEE; wd4 = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("%s_valid_c%0d", tag, k), 32'(v4), 32'(k == 4));
      chk($sformatf("%s_ready_c%0d", tag, k), 32'(rdy4), 32'(k == 4));
    end
    chk({tag, "_rdata"}, 32'(rd4), 32'(v.exp_rdata));
    chk({tag, "_proto"}, 32'(pe4), 32'(v.exp_pe));
    chk({tag, "_rc"}, 32'(rc4), 32'(v.exp_rc));
    chk({tag, "_wc"}, 32'(wc4), 32'(v.exp_wc));
  endtask

  initial begin
    logic [7:0] vals [4];
    vec_t       v;
    int         pulses;

    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

    //          rd    wr    addr   wdata  rdata  pe    rc      wc
    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 16'd0, 16'd1};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 16'd1, 16'd1};
    vecs[2] = '{1'b0, 1'b1, 8'h11, 8'h5A, 8'hA5, 1'b0, 16'd1, 16'd2};
    vecs[3] = '{1'b1, 1'b0, 8'h11, 8'h00, 8'h5A, 1'b0, 16'd2, 16'd2};
    vecs[4] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h5A, 1'b1, 16'd2, 16'd3};
    vecs[5] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b1, 16'd3, 16'd3};
    vecs[6] = '{1'b1, 1'b0, 8'h55, 8'h00, 8'h00, 1'b1, 16'd4, 16'd3};

    // Reset both instances
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    chk_reset4("rst0");

    for (int i = 0; i < 7; i++) begin
      run_txn4(vecs[i], $sformatf("v%0d", i));
    end

    // Reset during WAIT of a write, with a request held across the reset edge
    we4 = 1'b1; addr4 = 8'h30; wd4 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_wait_ready", 32'(rdy4), 32'd0);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0; we4 = 1'b0; addr4 = 8'h00; wd4 = 8'h00;
    chk_reset4("midrst");
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (v4) pulses++;
    end
    chk("midrst_no_valid", 32'(pulses), 32'd0);
    v = '{1'b1, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0, 16'd1, 16'd0};
    run_txn4(v, "rd30");
    v = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 16'd2, 16'd0};
    run_txn4(v, "rd10_cleared");

    // LATENCY=1: back-to-back writes then continuous reads
    rst1 = 1'b0;
    chk("l1_rst_ready", 32'(rdy1), 32'd1);
    chk("l1_rst_valid", 32'(v1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      we1 = 1'b1; re1 = 1'b0; addr1 = 8'(i); wd1 = vals[i];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("l1_wr%0d_valid", i), 32'(v1), 32'd1);
      chk($sformatf("l1_wr%0d_ready", i), 32'(rdy1), 32'd1);
      chk($sformatf("l1_wr%0d_wc", i), 32'(wc1), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      we1 = 1'b0; re1 = 1'b1; addr1 = 8'(i); wd1 = 8'h00;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("l1_rd%0d_valid", i), 32'(v1), 32'd1);
      chk($sformatf("l1_rd%0d_ready", i), 32'(rdy1), 32'd1);
      chk($sformatf("l1_rd%0d_data", i), 32'(rd1), 32'(vals[i]));
      chk($sformatf("l1_rd%0d_rc", i), 32'(rc1), 32'(i + 1));
    end

    // Drive write_count up to 16'hFFFF, then one more write wraps it
    re1 = 1'b0; we1 = 1'b1; addr1 = 8'h80; wd1 = 8'h01;
    repeat (65531) @(posedge clk);
    @(negedge clk);
    chk("l1_wc_max", 32'(wc1), 32'h0000_FFFF);
    @(posedge clk);
    @(negedge clk);
    we1 = 1'b0;
    chk("l1_wc_wrap", 32'(wc1), 32'd0);
    chk("l1_wrap_valid", 32'(v1), 32'd1);
    chk("l1_rdata_held", 32'(rd1), 32'(vals[3]));
    chk("l1_proto_clear", 32'(pe1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, data width.
REQ-003 The block SHALL have parameter LATENCY, default 4, cycles from acceptance to response; legal range 1..15.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port mem_addr  input  ADDR_W  request address.
REQ-007 The block SHALL have port mem_read_enable  input  1  read request.
REQ-008 The block SHALL have port mem_write_enable  input  1  write request.
REQ-009 The block SHALL have port mem_write_data  input  DATA_W  write data.
REQ-010 The block SHALL have port mem_read_data  output  DATA_W  read response data.
REQ-011 The block SHALL have port mem_valid  output  1  one-cycle response strobe for reads and write-acks.
REQ-012 The block SHALL have port mem_ready  output  1  responder can accept a request this cycle.
REQ-013 The block SHALL have port proto_err  output  1  sticky flag: read and write both high at acceptance.
REQ-014 The block SHALL have ports read_count and write_count  output  16 each  completed-operation counters.

Function
REQ-015 The block SHALL accept a request on an edge where mem_ready=1 and (mem_read_enable or mem_write_enable)=1, capturing addr, data and op.
REQ-016 The block SHALL ignore request inputs while mem_ready=0; requesters hold them until accepted.
REQ-017 The block SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-018 IDLE -> WAIT on acceptance with LATENCY>1, loading a down-counter with LATENCY-2; IDLE -> RESPOND on acceptance with LATENCY=1.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESPOND on the edge where the counter is 0.
REQ-020 RESPOND SHALL last one cycle, then go to WAIT/RESPOND on a new acceptance per REQ-018, else IDLE.
REQ-021 mem_ready SHALL be 1 in IDLE and RESPOND and 0 in WAIT, giving back-to-back throughput of one request per LATENCY cycles.
REQ-022 mem_valid SHALL be 1 exactly in RESPOND, i.e. LATENCY cycles after the accepting edge.
REQ-023 For reads, the edge entering RESPOND SHALL load mem_read_data from array[addr]; mem_read_data SHALL hold its value until the next read response.
REQ-024 For writes, the edge entering RESPOND SHALL commit data to array[addr]; mem_read_data SHALL be unchanged.
REQ-025 A read accepted after a write to the same address SHALL return the newly written value.
REQ-026 Both enables high at acceptance SHALL execute as a write and set proto_err until reset.
REQ-027 read_count/write_count SHALL increment on the edge entering RESPOND and wrap at 16'hFFFF -> 0.
REQ-028 Address SHALL index the full 2^ADDR_W array; no out-of-range case exists.

Reset
REQ-029 rst=1 SHALL force IDLE, counter 0, mem_valid 0, mem_ready 1, mem_read_data 0, proto_err 0, both counters 0, and zero every array entry.
REQ-030 rst asserted mid-operation SHALL abort the pending request with no array commit and no response strobe.
REQ-031 No request SHALL be accepted on an edge where rst=1.

Structure
REQ-032 A shared package mem_resp_pkg SHALL hold the state encoding (IDLE, WAIT, RESPOND), the op encoding, and the LATENCY default.
REQ-033 The storage array SHALL be a sub-module mem_resp_array with synchronous write, registered read, and a synchronous clear.
REQ-034 The FSM, counter and handshake SHALL live in main_mem_responder.

Verification
REQ-035 LATENCY=4: write addr 0x10 data 0xA5 accepted at edge 0 -> mem_valid high only in cycle 4, ready low cycles 1-3, write_count=1.
REQ-036 Read 0x10 right after REQ-035 -> mem_read_data=0xA5 with mem_valid 4 cycles after acceptance, read_count=1.
REQ-037 Continuous reads 0x00..0x03 with LATENCY=1 -> mem_ready constantly 1, mem_valid every cycle, data correct in order.
REQ-038 Both enables high, addr 0x20 data 0x3C -> treated as write, proto_err=1, later read of 0x20 returns 0x3C.
REQ-039 rst pulsed during WAIT of a write to 0x30 data 0xFF -> no mem_valid, a following read of 0x30 returns 0x00, all outputs at reset values.
REQ-040 Force write_count to 16'hFFFF, then complete one write -> write_count=0.
